univ_shift_reg: RTL

//  Parametrised universal shift register: hold, shift-right, shift-left, parallel load.

---
 rtl/univ_shift_reg_pkg.sv | 25 ++
 rtl/univ_shift_reg_fill_ctr.sv | 48 ++++
 rtl/univ_shift_reg.sv | 68 ++++++
 3 files changed

// File: rtl/univ_shift_reg_pkg.sv
`default_nettype none
// ============================================================================
// shift_pkg : mode encodings and helpers for the universal shift register
// Rev 1.0
// ============================================================================
package shift_pkg;

  typedef logic [1:0] shift_mode_t;

  localparam shift_mode_t MODE_HOLD = 2'b00;
  localparam shift_mode_t MODE_SHR  = 2'b01;
  localparam shift_mode_t MODE_SHL  = 2'b10;
  localparam shift_mode_t MODE_LOAD = 2'b11;

  // Counter must hold every value 0..width inclusive.
  function automatic int unsigned cnt_width(input int unsigned width);
    return $clog2(width + 1);
  endfunction

  function automatic logic is_shift(input shift_mode_t mode);
    return (mode == MODE_SHR) || (mode == MODE_SHL);
  endfunction

endpackage : shift_pkg
`default_nettype wire

// File: rtl/univ_shift_reg_fill_ctr.sv
`default_nettype none
// ============================================================================
// shift_fill_ctr : saturating count of valid bits since the last clear/load
// Rev 1.0
// ============================================================================
module shift_fill_ctr
  import shift_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  input  logic             load,
  output logic [CNT_W-1:0] cnt,
  output logic             full
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt_inc;
  logic             at_max;

  assign at_max  = (cnt == CNT_MAX);
  assign cnt_inc = at_max ? CNT_MAX : (cnt + CNT_ONE);

  // full tracks the registered count so both change on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt  <= '0;
      full <= 1'b0;
    end else if (clr) begin
      cnt  <= '0;
      full <= 1'b0;
    end else if (load) begin
      cnt  <= CNT_MAX;
      full <= 1'b1;
    end else if (inc) begin
      cnt  <= cnt_inc;
      full <= (cnt_inc == CNT_MAX);
    end
  end

endmodule : shift_fill_ctr
`default_nettype wire

// File: rtl/univ_shift_reg.sv
`default_nettype none
// ============================================================================
// univ_shift_reg : WIDTH-bit hold / shift-right / shift-left / load register
// Rev 1.0
// ============================================================================
module univ_shift_reg
  import shift_pkg::*;
#(
  parameter int               WIDTH   = 8,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic                         clr,
  input  logic [1:0]                   mode,
  input  logic                         sin_r,
  input  logic                         sin_l,
  input  logic [WIDTH-1:0]             pin,
  output logic [WIDTH-1:0]             q,
  output logic                         sout_r,
  output logic                         sout_l,
  output logic [$clog2(WIDTH+1)-1:0]   cnt,
  output logic                         full
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  logic inc;
  logic load;

  // Gating by en first keeps an unknown mode from reaching the counter.
  assign inc  = en && is_shift(shift_mode_t'(mode));
  assign load = en && (mode == MODE_LOAD);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= RST_VAL;
    end else if (clr) begin
      q <= RST_VAL;
    end else if (en) begin
      case (mode)
        MODE_SHR:  q <= {sin_r, q[WIDTH-1:1]};
        MODE_SHL:  q <= {q[WIDTH-2:0], sin_l};
        MODE_LOAD: q <= pin;
        default:   q <= q;
      endcase
    end
  end

  assign sout_r = q[0];
  assign sout_l = q[WIDTH-1];

  shift_fill_ctr #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_fill_ctr (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr),
    .inc  (inc),
    .load (load),
    .cnt  (cnt),
    .full (full)
  );

endmodule : univ_shift_reg
`default_nettype wire
